xbar_arbiter: RTL and testbench
===============================

Name: xbar_arbiter

Overview:
- Shares the single crossbar A/D channel, and with it the address decoder and slave ports (ZERO, ROM, UART, MMIO-BLK, RAM), between NM bus masters, e.g. instruction fetch, data LSU and the MMIO-BLK DMA.
- Round-robin arbitration with one outstanding transaction.
- Holds the grant from A-channel acceptance until the D-channel response has been delivered to the winning master.
- Sits between the masters and the crossbar address-decode/slave-mux stage.

Parameters:
- NM, 3, number of masters (2..8).
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only with XBAR_TIMEOUT_EN.

Ports:
- clk  in  1  clock (the block's single clock).
- reset_n  in  1  asynchronous active-low reset.
- m_a_valid  in  NM  per-master request valid.
- m_a_ready  out  NM  per-master request accept.
- m_a_opcode  in  3*NM  TileLink-UL opcode, master i at [3i+2:3i] (Get=4, PutFull=0, PutPartial=1).
- m_a_address  in  64*NM  request address.
- m_a_data  in  64*NM  write data.
- m_a_mask  in  8*NM  byte mask.
- m_d_valid  out  NM  response valid, one-hot to the granted master.
- m_d_ready  in  NM  per-master response accept.
- m_d_opcode  out  3  response opcode (AccessAck=0, AccessAckData=1), shared by all masters.
- m_d_data  out  64  response data, shared.
- m_d_error  out  1  response error/denied, shared.
- s_a_valid  out  1  request to crossbar.
- s_a_ready  in  1  crossbar accept.
- s_a_opcode  out  3  latched opcode.
- s_a_address  out  64  latched address.
- s_a_data  out  64  latched write data.
- s_a_mask  out  8  latched byte mask.
- s_d_valid  in  1  crossbar response valid.
- s_d_ready  out  1  response accept to crossbar.
- s_d_opcode  in  3  response opcode from crossbar.
- s_d_data  in  64  response data from crossbar.
- s_d_error  in  1  response error from crossbar.
- grant  out  NM  one-hot current owner; 0 when IDLE.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0.
  - All s_a_* payload registers, grant, busy, s_a_valid, s_d_ready, m_d_valid and m_a_ready are 0.
  - Reset mid-transaction abandons it silently; no response is delivered.
- States: IDLE, REQ, RESP (plus ERR with XBAR_TIMEOUT_EN).
- IDLE:
  - Winner = first i with m_a_valid[i], searching from rr_ptr upward with wrap-around.
  - m_a_ready[winner]=1, combinational, in that same cycle only.
  - On that edge: latch the winner's opcode/address/data/mask into the s_a_* registers, set grant, go to REQ.
  - No valid: stay in IDLE, all readies 0.
- REQ:
  - s_a_valid=1, payload stable.
  - On s_a_valid&&s_a_ready, go to RESP.
  - s_a_valid is first asserted the cycle after acceptance (1-cycle latency).
- RESP:
  - s_d_ready = m_d_ready[g].
  - m_d_valid[g] = s_d_valid; m_d_opcode/data/error pass through combinationally.
  - On handshake: go to IDLE, rr_ptr = (g+1) mod NM, grant = 0.
- s_d_ready=0 in IDLE and REQ.
- All m_d_valid bits other than the granted one are 0 at all times.
- Minimum turnaround is 3 cycles per transaction; no bypass from IDLE straight to REQ output.
- Simultaneous requests are resolved purely by rr_ptr. A master whose request is not accepted must hold m_a_valid and its payload.
- A master that keeps m_a_valid high after its response competes normally; rr_ptr has already moved past it.
- NM not a power of two: the pointer wraps from NM-1 to 0.

Optional Feature:
- Macro XBAR_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to REQ and RESP and increments each cycle spent waiting for s_a_ready (REQ) or s_d_valid (RESP).
  - When the counter reaches TIMEOUT_CYCLES-1 while still waiting, go to ERR; s_a_valid drops.
- ERR:
  - m_d_valid[g]=1, m_d_error=1, m_d_data=0.
  - m_d_opcode = 1 if the latched opcode is Get, else 0.
  - s_d_ready=1; any stray slave beat is discarded.
  - On m_d_ready[g], go to IDLE and rotate rr_ptr.
- Without the macro: no counter, no ERR state; the arbiter waits indefinitely and m_d_error = s_d_error.

Test Plan:
- Single master: m0 Get at 0x8000_0000, s_a_ready=1, response data 0xDEADBEEF after 2 cycles -> m_a_ready[0] pulses 1 cycle; s_a_valid the next cycle with address 0x8000_0000; m_d_valid[0] with data 0xDEADBEEF; grant returns to 0.
- All three masters request at the same time from reset -> service order m0, m1, m2. Then m0 and m2 request again -> order m0 then m2 (rr_ptr=0 after m2, then 1).
- Backpressure: s_a_ready low for 5 cycles, then m_d_ready[1] low for 3 cycles -> s_a_valid and payload held stable; s_d_ready tracks m_d_ready[1]; exactly one response beat is delivered.
- Reset asserted in RESP with s_d_valid=1 -> all outputs 0 immediately (asynchronous); after release the first grant goes to the lowest-index requester.
- XBAR_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts s_d_valid for a PutFull from m1 -> m_d_valid[1] with m_d_error=1, opcode 0, data 0 after 16 cycles in RESP. Then Get from m2 completes normally.
- Without the macro, same stimulus -> busy stays 1 for 1000+ cycles and m_d_valid is never asserted.

Source files
------------

// File: rtl/xbar_arbiter.sv
// rtl/xbar_arbiter.sv - round-robin arbiter sharing one crossbar A/D channel between NM masters
// Optional response watchdog (ERR state) enabled by defining XBAR_TIMEOUT_EN.
module xbar_arbiter #(
    parameter int NM             = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NM-1:0]        m_a_valid,
    output logic [NM-1:0]        m_a_ready,
    input  logic [3*NM-1:0]      m_a_opcode,
    input  logic [64*NM-1:0]     m_a_address,
    input  logic [64*NM-1:0]     m_a_data,
    input  logic [8*NM-1:0]      m_a_mask,
    output logic [NM-1:0]        m_d_valid,
    input  logic [NM-1:0]        m_d_ready,
    output logic [2:0]           m_d_opcode,
    output logic [63:0]          m_d_data,
    output logic                 m_d_error,
    output logic                 s_a_valid,
    input  logic                 s_a_ready,
    output logic [2:0]           s_a_opcode,
    output logic [63:0]          s_a_address,
    output logic [63:0]          s_a_data,
    output logic [7:0]           s_a_mask,
    input  logic                 s_d_valid,
    output logic                 s_d_ready,
    input  logic [2:0]           s_d_opcode,
    input  logic [63:0]          s_d_data,
    input  logic                 s_d_error,
    output logic [NM-1:0]        grant,
    output logic                 busy
);
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

`ifdef XBAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    logic [TW-1:0] tmo_q;
`else
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    state_t        state_q;
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] gidx_q;
    logic [NM-1:0] grant_q;
    logic          busy_q;
    logic          s_a_valid_q;
    logic [2:0]    op_q;
    logic [63:0]   addr_q;
    logic [63:0]   data_q;
    logic [7:0]    mask_q;

    logic [2:0]    op_arr   [NM];
    logic [63:0]   addr_arr [NM];
    logic [63:0]   data_arr [NM];
    logic [7:0]    mask_arr [NM];

    logic [PW-1:0] scan_idx;
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic [NM-1:0] win_oh;
    logic [PW-1:0] rr_next;
    logic          resp_hs;

    for (genvar i = 0; i < NM; i++) begin : g_unpack
        assign op_arr[i]   = m_a_opcode[3*i +: 3];
        assign addr_arr[i] = m_a_address[64*i +: 64];
        assign data_arr[i] = m_a_data[64*i +: 64];
        assign mask_arr[i] = m_a_mask[8*i +: 8];
    end

    // Search upward from rr_ptr with wrap at NM-1, not at the next power of two.
    always_comb begin
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NM; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NM);
            if (!win_found && m_a_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_oh = '0;
        if (win_found) win_oh[win_idx] = 1'b1;
    end

    assign rr_next = (gidx_q == PW'(NM - 1)) ? '0 : gidx_q + PW'(1);
    assign resp_hs = (state_q == RESP) && s_d_valid && m_d_ready[gidx_q];

    // Gated by reset_n so an asserted reset silences the accept immediately.
    assign m_a_ready = (state_q == IDLE && reset_n) ? win_oh : '0;

    always_comb begin
        s_d_ready  = 1'b0;
        m_d_valid  = '0;
        m_d_opcode = s_d_opcode;
        m_d_data   = s_d_data;
        m_d_error  = s_d_error;
        if (state_q == RESP) begin
            s_d_ready = m_d_ready[gidx_q];
            m_d_valid = grant_q & {NM{s_d_valid}};
        end
`ifdef XBAR_TIMEOUT_EN
        if (state_q == ERR) begin
            s_d_ready  = 1'b1;
            m_d_valid  = grant_q;
            m_d_error  = 1'b1;
            m_d_data   = '0;
            m_d_opcode = (op_q == 3'd4) ? 3'd1 : 3'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            s_a_valid_q <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
`ifdef XBAR_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (win_found) begin
                    op_q        <= op_arr[win_idx];
                    addr_q      <= addr_arr[win_idx];
                    data_q      <= data_arr[win_idx];
                    mask_q      <= mask_arr[win_idx];
                    gidx_q      <= win_idx;
                    grant_q     <= win_oh;
                    busy_q      <= 1'b1;
                    s_a_valid_q <= 1'b1;
                    state_q     <= REQ;
`ifdef XBAR_TIMEOUT_EN
                    tmo_q       <= '0;
`endif
                end
                REQ: begin
                    if (s_a_ready) begin
                        s_a_valid_q <= 1'b0;
                        state_q     <= RESP;
`ifdef XBAR_TIMEOUT_EN
                        tmo_q       <= '0;
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        s_a_valid_q <= 1'b0;
                        state_q     <= ERR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
`endif
                    end
                end
                RESP: begin
                    if (resp_hs) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_next;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
`ifdef XBAR_TIMEOUT_EN
                    end else if (!s_d_valid) begin
                        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_q <= ERR;
                        else                                  tmo_q   <= tmo_q + TW'(1);
`endif
                    end
                end
`ifdef XBAR_TIMEOUT_EN
                ERR: if (m_d_ready[gidx_q]) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= rr_next;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign s_a_valid   = s_a_valid_q;
    assign s_a_opcode  = op_q;
    assign s_a_address = addr_q;
    assign s_a_data    = data_q;
    assign s_a_mask    = mask_q;

endmodule

// File: tb/tb_xbar_arbiter.sv
// tb/tb_xbar_arbiter.sv - self-checking bench for xbar_arbiter with a round-robin reference model
module tb_xbar_arbiter;
    localparam int NM = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NM-1:0]   m_a_valid, m_a_ready, m_d_valid, m_d_ready, grant;
    logic [3*NM-1:0] m_a_opcode;
    logic [64*NM-1:0] m_a_address, m_a_data;
    logic [8*NM-1:0] m_a_mask;
    logic [2:0]      m_d_opcode, s_a_opcode, s_d_opcode;
    logic [63:0]     m_d_data, s_a_address, s_a_data, s_d_data;
    logic            m_d_error, s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error, busy;
    logic [7:0]      s_a_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;
    int svc_order[$];

    always #5 clk = ~clk;

    xbar_arbiter #(.NM(NM), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
        .m_a_address(m_a_address), .m_a_data(m_a_data), .m_a_mask(m_a_mask),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_data(m_d_data), .m_d_error(m_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_mask(s_a_mask),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_data(s_d_data), .s_d_error(s_d_error),
        .grant(grant), .busy(busy)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_a_valid = '0; m_a_opcode = '0; m_a_address = '0; m_a_data = '0; m_a_mask = '0;
        m_d_ready = '0; s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_opcode = '0;
        s_d_data = '0; s_d_error = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        model_rr = 0;
        tick();
    endtask

    function automatic logic [2:0] rand_op();
        int k;
        k = $urandom_range(0, 2);
        return (k == 0) ? 3'd4 : ((k == 1) ? 3'd0 : 3'd1);
    endfunction

    // Every master with requests left keeps m_a_valid high, so the service order
    // follows purely from the round-robin rule over non-empty queues.
    task automatic run_traffic(input int n0, input int n1, input int n2, input bit rnd);
        int cnt[NM];
        int sent[NM];
        int phase, owner, delay, budget, delivered, exp_w, total;
        logic [63:0] hd_addr[NM], hd_data[NM];
        logic [2:0]  hd_op[NM];
        logic [7:0]  hd_mask[NM];
        logic [63:0] cur_addr, cur_data;
        logic [2:0]  cur_op, exp_dop;
        logic [7:0]  cur_mask;
        logic [NM-1:0] exp_oh;
        cnt[0] = n0; cnt[1] = n1; cnt[2] = n2;
        total = n0 + n1 + n2;
        phase = 0; owner = 0; delay = 0; budget = 0; delivered = 0;
        cur_addr = '0; cur_data = '0; cur_op = '0; cur_mask = '0;
        for (int i = 0; i < NM; i++) begin
            sent[i] = 0;
            hd_addr[i] = {8'(i), 24'(0), 32'($urandom)};
            hd_data[i] = {32'($urandom), 32'($urandom)};
            hd_op[i] = rand_op();
            hd_mask[i] = 8'($urandom);
        end
        while ((cnt[0] + cnt[1] + cnt[2] > 0 || phase != 0) && budget < 4000) begin
            for (int i = 0; i < NM; i++) begin
                m_a_valid[i] = (cnt[i] > 0);
                m_a_opcode[3*i +: 3] = hd_op[i];
                m_a_address[64*i +: 64] = hd_addr[i];
                m_a_data[64*i +: 64] = hd_data[i];
                m_a_mask[8*i +: 8] = hd_mask[i];
            end
            s_a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_d_ready = rnd ? 3'($urandom) : 3'b111;
            exp_dop = (cur_op == 3'd4) ? 3'd1 : 3'd0;
            s_d_valid = (phase == 2 && delay == 0);
            s_d_data = ~cur_addr;
            s_d_opcode = exp_dop;
            s_d_error = cur_addr[0];
            #1;
            n_checks++;
            if ((m_d_valid & ~grant) !== '0) begin
                n_fail++; $display("FAIL d_valid_owner: m_d_valid=%b grant=%b", m_d_valid, grant);
            end
            if (phase == 0) begin
                exp_oh = '0; exp_w = -1;
                for (int k = 0; k < NM; k++)
                    if (exp_w < 0 && cnt[(model_rr + k) % NM] > 0) exp_w = (model_rr + k) % NM;
                if (exp_w >= 0) exp_oh[exp_w] = 1'b1;
                n_checks++;
                if (m_a_ready !== exp_oh) begin
                    n_fail++; $display("FAIL rr_winner: m_a_ready=%b want %b", m_a_ready, exp_oh);
                end
                if (exp_w >= 0) begin
                    owner = exp_w;
                    cur_addr = hd_addr[owner]; cur_data = hd_data[owner];
                    cur_op = hd_op[owner]; cur_mask = hd_mask[owner];
                    cnt[owner]--; sent[owner]++;
                    hd_addr[owner] = {8'(owner), 24'(sent[owner]), 32'($urandom)};
                    hd_data[owner] = {32'($urandom), 32'($urandom)};
                    hd_op[owner] = rand_op();
                    hd_mask[owner] = 8'($urandom);
                    svc_order.push_back(owner);
                    phase = 1;
                end
            end else if (phase == 1) begin
                exp_oh = '0; exp_oh[owner] = 1'b1;
                n_checks++;
                if (s_a_valid !== 1'b1 || m_a_ready !== '0 || grant !== exp_oh || busy !== 1'b1 ||
                    s_a_address !== cur_addr || s_a_data !== cur_data ||
                    s_a_opcode !== cur_op || s_a_mask !== cur_mask) begin
                    n_fail++;
                    $display("FAIL req_phase: v=%b grant=%b addr=%h op=%0d want grant=%b addr=%h op=%0d",
                             s_a_valid, grant, s_a_address, s_a_opcode, exp_oh, cur_addr, cur_op);
                end
                if (s_a_ready) begin
                    phase = 2;
                    delay = rnd ? $urandom_range(0, 4) : 0;
                end
            end else begin
                n_checks++;
                if (s_a_valid !== 1'b0 || s_d_ready !== m_d_ready[owner]) begin
                    n_fail++;
                    $display("FAIL resp_ready: s_a_valid=%b s_d_ready=%b want 0 %b",
                             s_a_valid, s_d_ready, m_d_ready[owner]);
                end
                exp_oh = '0;
                if (s_d_valid) exp_oh[owner] = 1'b1;
                n_checks++;
                if (m_d_valid !== exp_oh ||
                    (s_d_valid && (m_d_data !== ~cur_addr || m_d_error !== cur_addr[0] ||
                                   m_d_opcode !== exp_dop))) begin
                    n_fail++;
                    $display("FAIL resp_beat: valid=%b data=%h err=%b op=%0d want %b %h %b %0d",
                             m_d_valid, m_d_data, m_d_error, m_d_opcode, exp_oh, ~cur_addr,
                             cur_addr[0], exp_dop);
                end
                if (s_d_valid && m_d_ready[owner]) begin
                    phase = 0;
                    model_rr = (owner + 1) % NM;
                    delivered++;
                end else if (!s_d_valid) begin
                    delay--;
                end
            end
            tick();
            budget++;
        end
        n_checks++;
        if (budget >= 4000 || delivered != total) begin
            n_fail++;
            $display("FAIL traffic_done: delivered=%0d want %0d cycles=%0d", delivered, total, budget);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        m_a_valid = 3'b111;
        reset_n = 1'b0;
        tick();
        n_checks++;
        if (grant !== '0 || busy !== 1'b0 || s_a_valid !== 1'b0 || s_d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b busy=%b s_a_valid=%b s_d_ready=%b want 0",
                     grant, busy, s_a_valid, s_d_ready);
        end
        n_checks++;
        if (m_d_valid !== '0 || m_a_ready !== '0) begin
            n_fail++; $display("FAIL reset_hs: m_d_valid=%b m_a_ready=%b want 0", m_d_valid, m_a_ready);
        end
        n_checks++;
        if (s_a_address !== '0 || s_a_data !== '0 || s_a_opcode !== '0 || s_a_mask !== '0) begin
            n_fail++; $display("FAIL reset_payload: addr=%h data=%h op=%0d mask=%h want 0",
                               s_a_address, s_a_data, s_a_opcode, s_a_mask);
        end
        m_a_valid = '0;
        reset_n = 1'b1;
        model_rr = 0;
        tick();
    endtask

    task automatic test_single();
        m_a_valid = 3'b001;
        m_a_opcode[2:0] = 3'd4;
        m_a_address[63:0] = 64'h8000_0000;
        m_a_mask[7:0] = 8'hff;
        #1;
        n_checks++;
        if (m_a_ready !== 3'b001 || s_a_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: m_a_ready=%b s_a_valid=%b want 001 0", m_a_ready, s_a_valid);
        end
        tick();
        n_checks++;
        if (m_a_ready !== '0 || s_a_valid !== 1'b1 || s_a_address !== 64'h8000_0000 ||
            s_a_opcode !== 3'd4 || grant !== 3'b001 || busy !== 1'b1 || s_d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req: rdy=%b v=%b addr=%h op=%0d grant=%b busy=%b",
                     m_a_ready, s_a_valid, s_a_address, s_a_opcode, grant, busy);
        end
        m_a_valid = '0;
        s_a_ready = 1'b1;
        m_d_ready = 3'b001;
        tick();
        s_a_ready = 1'b0;
        tick();
        s_d_valid = 1'b1;
        s_d_data = 64'hDEAD_BEEF;
        s_d_opcode = 3'd1;
        #1;
        n_checks++;
        if (m_d_valid !== 3'b001 || m_d_data !== 64'hDEAD_BEEF || m_d_opcode !== 3'd1 || s_d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_resp: valid=%b data=%h op=%0d s_d_ready=%b want 001 deadbeef 1 1",
                     m_d_valid, m_d_data, m_d_opcode, s_d_ready);
        end
        tick();
        s_d_valid = 1'b0;
        #1;
        n_checks++;
        if (grant !== '0 || busy !== 1'b0 || m_d_valid !== '0) begin
            n_fail++; $display("FAIL single_done: grant=%b busy=%b m_d_valid=%b want 0", grant, busy, m_d_valid);
        end
        idle_inputs();
        model_rr = 1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        svc_order.delete();
        run_traffic(1, 1, 1, 1'b0);
        n_checks++;
        if (svc_order.size() != 3 || svc_order[0] != 0 || svc_order[1] != 1 || svc_order[2] != 2) begin
            n_fail++; $display("FAIL order_012: got %p want 0 1 2", svc_order);
        end
        svc_order.delete();
        run_traffic(1, 0, 1, 1'b0);
        n_checks++;
        if (svc_order.size() != 2 || svc_order[0] != 0 || svc_order[1] != 2) begin
            n_fail++; $display("FAIL order_02: got %p want 0 2", svc_order);
        end
    endtask

    task automatic test_backpressure();
        int bad, beats;
        m_a_valid = 3'b010;
        m_a_opcode[5:3] = 3'd1;
        m_a_address[127:64] = 64'h1000_0040;
        m_a_data[127:64] = 64'hA5A5_5A5A_0F0F_F0F0;
        m_a_mask[15:8] = 8'h0f;
        #1;
        n_checks++;
        if (m_a_ready !== 3'b010) begin
            n_fail++; $display("FAIL bp_accept: m_a_ready=%b want 010", m_a_ready);
        end
        tick();
        m_a_valid = '0;
        m_a_address = '0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (s_a_valid !== 1'b1 || s_a_address !== 64'h1000_0040 ||
                s_a_data !== 64'hA5A5_5A5A_0F0F_F0F0 || s_a_mask !== 8'h0f || s_a_opcode !== 3'd1) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        s_a_ready = 1'b1;
        tick();
        s_a_ready = 1'b0;
        s_d_valid = 1'b1;
        s_d_data = 64'h0123_4567_89AB_CDEF;
        beats = 0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (s_d_ready !== 1'b0 || m_d_valid !== 3'b010) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_dstall: %0d bad cycles want 0", bad);
        end
        m_d_ready = 3'b010;
        #1;
        n_checks++;
        if (s_d_ready !== 1'b1 || m_d_data !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++; $display("FAIL bp_dready: s_d_ready=%b data=%h want 1 0123456789abcdef", s_d_ready, m_d_data);
        end
        if (m_d_valid[1] && m_d_ready[1]) beats++;
        tick();
        if (m_d_valid[1] && m_d_ready[1]) beats++;
        n_checks++;
        if (beats != 1 || s_d_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_beats: beats=%0d s_d_ready=%b want 1 0", beats, s_d_ready);
        end
        idle_inputs();
        model_rr = 2;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            run_traffic($urandom_range(2, 6), $urandom_range(2, 6), $urandom_range(2, 6), 1'b1);
    endtask

    task automatic test_reset_midflight();
        m_a_valid = 3'b001;
        m_a_address[63:0] = 64'h4000;
        tick();
        m_a_valid = '0;
        s_a_ready = 1'b1;
        tick();
        s_a_ready = 1'b0;
        s_d_valid = 1'b1;
        m_d_ready = '0;
        #1;
        n_checks++;
        if (m_d_valid !== 3'b001) begin
            n_fail++; $display("FAIL mid_pre: m_d_valid=%b want 001", m_d_valid);
        end
        #2;
        reset_n = 1'b0;
        m_a_valid = 3'b110;
        #1;
        n_checks++;
        if (m_d_valid !== '0 || grant !== '0 || busy !== 1'b0 || s_d_ready !== 1'b0 ||
            s_a_valid !== 1'b0 || m_a_ready !== '0) begin
            n_fail++;
            $display("FAIL mid_async: d_valid=%b grant=%b busy=%b s_d_ready=%b a_ready=%b want 0",
                     m_d_valid, grant, busy, s_d_ready, m_a_ready);
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (m_a_ready !== 3'b010) begin
            n_fail++; $display("FAIL mid_first_grant: m_a_ready=%b want 010", m_a_ready);
        end
        idle_inputs();
        model_rr = 0;
        tick();
    endtask

    task automatic test_timeout_behaviour();
        int k;
        m_a_valid = 3'b010;
        m_a_opcode[5:3] = 3'd0;
        m_a_address[127:64] = 64'h2000;
        tick();
        m_a_valid = '0;
        s_a_ready = 1'b1;
        tick();
        s_a_ready = 1'b0;
`ifdef XBAR_TIMEOUT_EN
        k = 0;
        while (m_d_valid === '0 && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (k != 16 || m_d_valid !== 3'b010 || m_d_error !== 1'b1 || m_d_opcode !== 3'd0 ||
            m_d_data !== '0 || s_d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err: cycles=%0d valid=%b err=%b op=%0d data=%h want 16 010 1 0 0",
                     k, m_d_valid, m_d_error, m_d_opcode, m_d_data);
        end
        m_d_ready = 3'b010;
        tick();
        m_d_ready = '0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_release: busy=%b want 0", busy);
        end
        model_rr = 2;
        run_traffic(0, 0, 1, 1'b0);
`else
        k = 0;
        for (int c = 0; c < 1000; c++) begin
            if (busy !== 1'b1 || m_d_valid !== '0) k++;
            tick();
        end
        n_checks++;
        if (k != 0) begin
            n_fail++; $display("FAIL no_timeout_wait: %0d bad cycles want 0", k);
        end
        do_reset();
`endif
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_timeout_behaviour();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
